mem_port_arbiter: RTL and testbench

Shares the processor's single-port synchronous data/instruction memory between the instruction-fetch requester (PC path) and the data requester (push/pop stack-memory instructions). Grants at most one access per cycle, returns read data one cycle later tagged to the winner, and raises a fetch stall toward the PC write enable whenever fetch loses arbitration. It sits between the control/PC logic and the memory macro.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// requester and the data (push/pop) requester. At most one access is granted
// per cycle. Read data returns one cycle after the grant and is tagged to the
// requester that won. `stall` tells the PC path that fetch lost this cycle.
//
// Optional feature macro: ARB_FAIRNESS_EN
//   undefined : strict data priority, fetch may starve under continuous d_req
//   defined   : after MAX_DATA_STREAK data wins while fetch waits, fetch is
//               granted once and the streak restarts
//
// Ports
//   CLK, reset            clock; synchronous active-high reset
//   f_req/f_addr          fetch request and address
//   f_gnt                 fetch granted this cycle (combinational)
//   f_rvalid/f_rdata      fetch read return, one cycle after f_gnt
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 write, 0 read)
//   d_gnt                 data granted this cycle (combinational)
//   d_rvalid/d_rdata      data read return, one cycle after a read d_gnt
//   stall                 f_req & ~f_gnt, gates PC write enable
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (winner mux)
//   mem_rdata             memory read data, valid the cycle after a read

module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned MAX_DATA_STREAK = 3
) (
  input  logic              CLK,
  input  logic              reset,

  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              stall,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Who owns the read data arriving on mem_rdata this cycle.
  typedef enum logic [1:0] {
    OwnNone  = 2'd0,
    OwnFetch = 2'd1,
    OwnData  = 2'd2
  } owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   fetch_force;

  // ---------------------------------------------------------------------------
  // Fairness streak counter
  // ---------------------------------------------------------------------------
`ifdef ARB_FAIRNESS_EN
  logic [3:0] streak_q, streak_d;

  assign fetch_force = (streak_q == 4'(MAX_DATA_STREAK));

  always_comb begin
    streak_d = streak_q;
    if (f_gnt || !f_req) begin
      streak_d = 4'd0;
    end else if (d_gnt && (streak_q != 4'hf)) begin
      // f_req is high here, so this counts a data win over a waiting fetch.
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant logic: data wins a collision unless fairness forces fetch.
  // ---------------------------------------------------------------------------
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !(f_req && fetch_force)) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign stall = f_req & ~f_gnt & ~reset;

  // ---------------------------------------------------------------------------
  // Memory command mux; all-zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign mem_en = f_gnt | d_gnt;

  // ---------------------------------------------------------------------------
  // Read return tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_owner_d = OwnNone;
    if (f_gnt) begin
      rd_owner_d = OwnFetch;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OwnData;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_owner_q <= OwnNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Masking with reset drops a return whose grant was followed by reset.
  assign f_rvalid = (rd_owner_q == OwnFetch) & ~reset;
  assign d_rvalid = (rd_owner_q == OwnData) & ~reset;
  assign f_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  // ---------------------------------------------------------------------------
  // Sanity checks
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    assert (MAX_DATA_STREAK >= 1 && MAX_DATA_STREAK <= 15);
    assert (!(f_gnt && d_gnt));
    assert (!(mem_we && f_gnt));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter. Each table row is one
// clock cycle: inputs are driven 1 time unit after the rising edge and all
// outputs are compared 1 unit later. The memory model returns
// (address ^ 16'h7015) on the cycle after a read.

module tb_mem_port_arbiter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_gnt, f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        stall, mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (16),
    .MAX_DATA_STREAK(3)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .stall    (stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory model.
  always @(posedge CLK) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 16'h7015;
  end

  typedef struct {
    logic        rst;
    logic        fr;
    logic [15:0] fa;
    logic        dr;
    logic        dwe;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        e_fgnt;
    logic        e_dgnt;
    logic        e_stall;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_frv;
    logic        e_drv;
    logic [15:0] e_rdata;
  } vec_t;

  localparam int NumVecs = 16;
  vec_t vecs[NumVecs];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fr, input logic [15:0] fa, input logic dr,
                       input logic dwe, input logic [15:0] da, input logic [15:0] dwd);
    @(posedge CLK);
    #1;
    reset   = rst;
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    #1;
  endtask

  initial begin
    //          rst fr fa        dr dwe da        dwd        fg dg st en we addr      wdata      frv drv rdata
    vecs[0]  = '{H, H, 16'h0020, H, L, 16'h0100, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};
    vecs[1]  = '{H, H, 16'h0020, H, L, 16'h0100, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};
    // Release: collision, data wins, fetch stalls.
    vecs[2]  = '{L, H, 16'h0020, H, L, 16'h0100, 16'h0000, L, H, H, H, L, 16'h0100, 16'h0000, L, L, 16'h0000};
    vecs[3]  = '{L, H, 16'h0020, L, L, 16'h0000, 16'h0000, H, L, L, H, L, 16'h0020, 16'h0000, L, H, 16'h7115};
    vecs[4]  = '{L, H, 16'h0010, L, L, 16'h0000, 16'h0000, H, L, L, H, L, 16'h0010, 16'h0000, H, L, 16'h7035};
    vecs[5]  = '{L, L, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, H, L, 16'h7005};
    // Data write, then no rvalid.
    vecs[6]  = '{L, L, 16'h0000, H, H, 16'h0200, 16'hbeef, L, H, L, H, H, 16'h0200, 16'hbeef, L, L, 16'h0000};
    vecs[7]  = '{L, L, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};
    // Back-to-back read then write.
    vecs[8]  = '{L, L, 16'h0000, H, L, 16'h0300, 16'h0000, L, H, L, H, L, 16'h0300, 16'h0000, L, L, 16'h0000};
    vecs[9]  = '{L, L, 16'h0000, H, H, 16'h0301, 16'h5a5a, L, H, L, H, H, 16'h0301, 16'h5a5a, L, H, 16'h7315};
    // Fetch read, then reset drops its return.
    vecs[10] = '{L, H, 16'h0040, L, L, 16'h0000, 16'h0000, H, L, L, H, L, 16'h0040, 16'h0000, L, L, 16'h0000};
    vecs[11] = '{H, H, 16'h0040, H, L, 16'h0100, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};
    vecs[12] = '{L, L, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};
    // Fetch loses then withdraws: no fetch grant or return.
    vecs[13] = '{L, H, 16'h0060, H, L, 16'h0500, 16'h0000, L, H, H, H, L, 16'h0500, 16'h0000, L, L, 16'h0000};
    vecs[14] = '{L, L, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, H, 16'h7515};
    vecs[15] = '{L, L, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, L, L, 16'h0000, 16'h0000, L, L, 16'h0000};

    for (int i = 0; i < NumVecs; i++) begin
      drive(vecs[i].rst, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
      chk1($sformatf("v%0d.f_gnt", i), f_gnt, vecs[i].e_fgnt);
      chk1($sformatf("v%0d.d_gnt", i), d_gnt, vecs[i].e_dgnt);
      chk1($sformatf("v%0d.stall", i), stall, vecs[i].e_stall);
      chk1($sformatf("v%0d.mem_en", i), mem_en, vecs[i].e_en);
      chk1($sformatf("v%0d.mem_we", i), mem_we, vecs[i].e_we);
      chk16($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      chk16($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk1($sformatf("v%0d.f_rvalid", i), f_rvalid, vecs[i].e_frv);
      chk1($sformatf("v%0d.d_rvalid", i), d_rvalid, vecs[i].e_drv);
      if (vecs[i].e_frv) chk16($sformatf("v%0d.f_rdata", i), f_rdata, vecs[i].e_rdata);
      if (vecs[i].e_drv) chk16($sformatf("v%0d.d_rdata", i), d_rdata, vecs[i].e_rdata);
    end

    // Continuous collision for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      logic exp_f;
`ifdef ARB_FAIRNESS_EN
      exp_f = ((i % 4) == 3);
`else
      exp_f = 1'b0;
`endif
      drive(L, H, 16'h0050, H, L, 16'h0400, 16'h0000);
      chk1($sformatf("streak%0d.f_gnt", i), f_gnt, exp_f);
      chk1($sformatf("streak%0d.d_gnt", i), d_gnt, ~exp_f);
      chk1($sformatf("streak%0d.stall", i), stall, ~exp_f);
      chk16($sformatf("streak%0d.mem_addr", i), mem_addr, exp_f ? 16'h0050 : 16'h0400);
    end

    // Drop both requests: streak must restart from zero afterwards.
    drive(L, L, 16'h0000, L, L, 16'h0000, 16'h0000);
    chk1("idle.mem_en", mem_en, L);
    drive(L, H, 16'h0050, H, L, 16'h0400, 16'h0000);
    chk1("restart.d_gnt", d_gnt, H);
    chk1("restart.stall", stall, H);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
